vga_timing_pipe: RTL and testbench
==================================

// Module: vga_timing_pipe
// PURPOSE
//  Parametrised VGA timing generator/driver for the character display path.
//  Produces char-buffer read coordinates from free-running h/v counters and
//  delays sync/blank by a configurable read latency so colour and sync align.
//  Blanks RGB outside the active area and flags frame/line starts.
//  Sits between the character buffer/font ROM and the VGA pins.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line (true count, not count-1)
//  H_FRONT     16   h front porch, clocks
//  H_PULSE     96   h sync width, clocks
//  H_BACK      48   h back porch, clocks
//  V_ACTIVE    480  visible lines per frame
//  V_FRONT     10   v front porch, lines
//  V_PULSE     2    v sync width, lines
//  V_BACK      33   v back porch, lines
//  HS_POL      0    asserted level of VGA_HS (0 = active-low)
//  VS_POL      0    asserted level of VGA_VS
//  CW_LOG2     3    log2 character cell width, pixels
//  CH_LOG2     3    log2 character cell height, lines
//  READ_LAT    1    cycles from read address to pixel_* valid, 1..4
//  Derived: HT=sum H_*, VT=sum V_*, HW=$clog2(HT), VW=$clog2(VT)
// PORTS
//  clk_25M      in   1           pixel clock
//  rst          in   1           synchronous reset, active-low
//  read_en      out  1           current address is in active area
//  read_hchar   out  HW-CW_LOG2  character column
//  read_vchar   out  VW-CH_LOG2  character row
//  read_hoffset out  CW_LOG2     pixel column within cell
//  read_voffset out  CH_LOG2     pixel row within cell
//  pixel_red    in   4           colour for address issued READ_LAT cycles ago
//  pixel_green  in   4
//  pixel_blue   in   4
//  VGA_R/G/B    out  4 each      registered, blanked colour
//  VGA_HS       out  1           registered h sync, polarity HS_POL
//  VGA_VS       out  1           registered v sync, polarity VS_POL
//  frame_start  out  1           1-cycle pulse with first active pixel at pins
//  line_start   out  1           1-cycle pulse with first pixel of each active line
// BEHAVIOUR
//  - h_cnt 0..HT-1, +1/cycle, wraps to 0; v_cnt +1 when h_cnt wraps, wraps
//    0..VT-1 (v wraps same cycle h wraps at HT-1,VT-1).
//  - active(t) = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; read_en = active (comb).
//  - Address (comb): {hchar,hoffset}=h_cnt, {vchar,voffset}=v_cnt when
//    read_en, else all zero.
//  - hs_raw asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_PULSE;
//    vs_raw likewise on v_cnt; both full-line granularity on v.
//  - active, hs_raw, vs_raw, frame/line flags pass through READ_LAT-stage
//    shift regs; outputs registered once more: pins lag counters READ_LAT+1.
//  - VGA_RGB <= delayed_active ? pixel_* : 0 (pixel_* sampled at t+READ_LAT).
//  - frame_start: h_cnt==0&&v_cnt==0 delayed; line_start: h_cnt==0&&
//    v_cnt<V_ACTIVE delayed (both high on frame's first pixel).
//  - Reset (rst==0 at edge): counters 0, all pipeline stages inactive;
//    VGA_RGB=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, pulses 0. Mid-frame reset
//    aborts frame; first frame after release starts at h=v=0 with no stale
//    sync/colour emitted.
//  - Elaboration error if READ_LAT outside 1..4 or H_ACTIVE/V_ACTIVE not
//    multiple of cell size.
// TESTING
//  1 Defaults, reset released cycle 0 -> read_en=1 at cycles 0..639 of line 0;
//    VGA_HS==0 exactly for cycles 658..753 (656..751 + 2), period 800.
//  2 Defaults -> VGA_VS==0 for lines 490..491; frame_start every 420000
//    cycles, first at cycle 2; line_start 480 times per frame.
//  3 pixel_* = f(address delayed READ_LAT) with READ_LAT=3 -> VGA_R at pin
//    equals f(h_cnt) 4 cycles later; zero when h_cnt>=640.
//  4 HS_POL=1,VS_POL=1, 800x600-style params (40/128/88, 1/4/23) -> sync
//    active-high, HT=1056, VT=628 measured.
//  5 Assert rst at line 200, cycle 300 for 5 cycles -> outputs go to reset
//    values next edge; after release h=v=0, frame_start 2 cycles later.
//  6 Address at h_cnt=639,v_cnt=479 -> hchar=79,hoff=7,vchar=59,voff=7;
//    h_cnt=640 -> all zero, read_en=0.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// VGA timing generator: free-running h/v counters drive character-buffer read
// addresses, while sync/blank/flags are delayed to line up with returned pixel colour.
module vga_timing_pipe #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_PULSE  = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_PULSE  = 2,
    parameter int unsigned V_BACK   = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW_LOG2  = 3,
    parameter int unsigned CH_LOG2  = 3,
    parameter int unsigned READ_LAT = 1,
    localparam int unsigned HT = H_ACTIVE + H_FRONT + H_PULSE + H_BACK,
    localparam int unsigned VT = V_ACTIVE + V_FRONT + V_PULSE + V_BACK,
    localparam int unsigned HW = $clog2(HT),
    localparam int unsigned VW = $clog2(VT)
) (
    input  logic                    clk_25M,
    input  logic                    rst,
    output logic                    read_en,
    output logic [HW-CW_LOG2-1:0]   read_hchar,
    output logic [VW-CH_LOG2-1:0]   read_vchar,
    output logic [CW_LOG2-1:0]      read_hoffset,
    output logic [CH_LOG2-1:0]      read_voffset,
    input  logic [3:0]              pixel_red,
    input  logic [3:0]              pixel_green,
    input  logic [3:0]              pixel_blue,
    output logic [3:0]              VGA_R,
    output logic [3:0]              VGA_G,
    output logic [3:0]              VGA_B,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    frame_start,
    output logic                    line_start
);

    localparam int unsigned HS_ON  = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_OFF = HS_ON + H_PULSE;
    localparam int unsigned VS_ON  = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_OFF = VS_ON + V_PULSE;
    localparam int unsigned NFLAG  = 5;
    localparam int unsigned SRW    = NFLAG * READ_LAT;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("vga_timing_pipe: READ_LAT must lie in 1..4");
    end
    if ((H_ACTIVE % (1 << CW_LOG2)) != 0 || (V_ACTIVE % (1 << CH_LOG2)) != 0) begin : g_bad_cell
        $error("vga_timing_pipe: active area must be a whole number of character cells");
    end

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [HW:0]      h_ext;
    logic [VW:0]      v_ext;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [NFLAG-1:0] flags_now;
    logic [NFLAG-1:0] flags_out;
    logic [SRW-1:0]   flag_sr;

    // Raster counters; v advances (and both wrap) on the last pixel of a line.
    always_ff @(posedge clk_25M) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(HT - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(VT - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // One extra bit so a sync window ending exactly at HT/VT still compares correctly.
    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_raw = (h_ext >= (HW+1)'(HS_ON)) && (h_ext < (HW+1)'(HS_OFF));
    assign vs_raw = (v_ext >= (VW+1)'(VS_ON)) && (v_ext < (VW+1)'(VS_OFF));

    assign read_en      = active;
    assign read_hchar   = active ? h_cnt[HW-1:CW_LOG2] : '0;
    assign read_hoffset = active ? h_cnt[CW_LOG2-1:0]  : '0;
    assign read_vchar   = active ? v_cnt[VW-1:CH_LOG2] : '0;
    assign read_voffset = active ? v_cnt[CH_LOG2-1:0]  : '0;

    assign flags_now = {active, hs_raw, vs_raw,
                        (h_cnt == '0) && (v_cnt == '0),
                        (h_cnt == '0) && (v_cnt < VW'(V_ACTIVE))};
    assign flags_out = flag_sr[SRW-1 -: NFLAG];

    // Flags ride a READ_LAT-deep shift register so they meet the pixel returned for them.
    always_ff @(posedge clk_25M) begin
        if (!rst) begin
            flag_sr     <= '0;
            VGA_R       <= 4'h0;
            VGA_G       <= 4'h0;
            VGA_B       <= 4'h0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            flag_sr     <= SRW'({flag_sr, flags_now});
            VGA_R       <= flags_out[4] ? pixel_red   : 4'h0;
            VGA_G       <= flags_out[4] ? pixel_green : 4'h0;
            VGA_B       <= flags_out[4] ? pixel_blue  : 4'h0;
            VGA_HS      <= flags_out[3] ? HS_POL : ~HS_POL;
            VGA_VS      <= flags_out[2] ? VS_POL : ~VS_POL;
            frame_start <= flags_out[1];
            line_start  <= flags_out[0];
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: a 640x480 default instance and a tiny active-high
// sync instance with READ_LAT=3, both checked cycle by cycle against a raster model.
module tb_vga_timing_pipe;

    typedef struct packed {
        logic [3:0] r, g, b;
        logic       hs, vs, fs, ls;
    } pins_t;

    typedef struct packed {
        logic       en;
        logic [6:0] hc, vc;
        logic [2:0] ho, vo;
    } addr_t;

    localparam int HA  [2] = '{640, 16};
    localparam int HF  [2] = '{16, 2};
    localparam int HP  [2] = '{96, 3};
    localparam int HB  [2] = '{48, 3};
    localparam int VA  [2] = '{480, 8};
    localparam int VF  [2] = '{10, 1};
    localparam int VP  [2] = '{2, 2};
    localparam int VB  [2] = '{33, 2};
    localparam int LAT [2] = '{1, 3};
    localparam int CWL [2] = '{3, 2};
    localparam int CHL [2] = '{3, 2};
    localparam int POL [2] = '{0, 1};

    logic        clk;
    logic        rst;
    logic [11:0] px [2];

    logic       d0_en, d0_hs, d0_vs, d0_fs, d0_ls;
    logic [6:0] d0_hc, d0_vc;
    logic [2:0] d0_ho, d0_vo;
    logic [3:0] d0_r, d0_g, d0_b;
    logic       d1_en, d1_hs, d1_vs, d1_fs, d1_ls;
    logic [2:0] d1_hc;
    logic [1:0] d1_vc, d1_ho, d1_vo;
    logic [3:0] d1_r, d1_g, d1_b;

    vga_timing_pipe dut0 (
        .clk_25M(clk), .rst(rst),
        .read_en(d0_en), .read_hchar(d0_hc), .read_vchar(d0_vc),
        .read_hoffset(d0_ho), .read_voffset(d0_vo),
        .pixel_red(px[0][11:8]), .pixel_green(px[0][7:4]), .pixel_blue(px[0][3:0]),
        .VGA_R(d0_r), .VGA_G(d0_g), .VGA_B(d0_b),
        .VGA_HS(d0_hs), .VGA_VS(d0_vs), .frame_start(d0_fs), .line_start(d0_ls)
    );

    vga_timing_pipe #(
        .H_ACTIVE(HA[1]), .H_FRONT(HF[1]), .H_PULSE(HP[1]), .H_BACK(HB[1]),
        .V_ACTIVE(VA[1]), .V_FRONT(VF[1]), .V_PULSE(VP[1]), .V_BACK(VB[1]),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW_LOG2(CWL[1]), .CH_LOG2(CHL[1]),
        .READ_LAT(LAT[1])
    ) dut1 (
        .clk_25M(clk), .rst(rst),
        .read_en(d1_en), .read_hchar(d1_hc), .read_vchar(d1_vc),
        .read_hoffset(d1_ho), .read_voffset(d1_vo),
        .pixel_red(px[1][11:8]), .pixel_green(px[1][7:4]), .pixel_blue(px[1][3:0]),
        .VGA_R(d1_r), .VGA_G(d1_g), .VGA_B(d1_b),
        .VGA_HS(d1_hs), .VGA_VS(d1_vs), .frame_start(d1_fs), .line_start(d1_ls)
    );

    pins_t pins_obs [2];
    addr_t addr_obs [2];
    assign pins_obs[0] = {d0_r, d0_g, d0_b, d0_hs, d0_vs, d0_fs, d0_ls};
    assign pins_obs[1] = {d1_r, d1_g, d1_b, d1_hs, d1_vs, d1_fs, d1_ls};
    assign addr_obs[0] = {d0_en, d0_hc, d0_vc, d0_ho, d0_vo};
    assign addr_obs[1] = {d1_en, 7'(d1_hc), 7'(d1_vc), 3'(d1_ho), 3'(d1_vo)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          errs = 0;
    int          cyc = 0;
    int          h [2];
    int          v [2];
    pins_t       sb0 [$];
    pins_t       sb1 [$];
    logic [11:0] hist [2][5];
    logic        prev_hs0, prev_vs1;
    int          hs_fall0 [$], hs_rise0 [$], fs0 [$], ls0 [$];
    int          fs1 [$], ls1 [$], vs1_rise [$], vs1_fall [$];
    addr_t       a639, a640, b183, b184;

    function automatic int ht(int d);
        return HA[d] + HF[d] + HP[d] + HB[d];
    endfunction

    function automatic int vt(int d);
        return VA[d] + VF[d] + VP[d] + VB[d];
    endfunction

    // Stand-in for the character buffer + font ROM: any address-dependent colour.
    function automatic logic [11:0] colour(int hh, int vv);
        return {4'(hh), 4'(hh >> 4) ^ 4'(vv), 4'(vv + (hh >> 2))};
    endfunction

    function automatic pins_t idle(int d);
        pins_t p;
        p    = '0;
        p.hs = ~POL[d][0];
        p.vs = ~POL[d][0];
        return p;
    endfunction

    function automatic pins_t expect_pins(int d, int hh, int vv, logic [11:0] col);
        pins_t p;
        logic  act, hs_a, vs_a;
        act  = (hh < HA[d]) && (vv < VA[d]);
        hs_a = (hh >= HA[d] + HF[d]) && (hh < HA[d] + HF[d] + HP[d]);
        vs_a = (vv >= VA[d] + VF[d]) && (vv < VA[d] + VF[d] + VP[d]);
        p.r  = act ? col[11:8] : 4'h0;
        p.g  = act ? col[7:4]  : 4'h0;
        p.b  = act ? col[3:0]  : 4'h0;
        p.hs = hs_a ? POL[d][0] : ~POL[d][0];
        p.vs = vs_a ? POL[d][0] : ~POL[d][0];
        p.fs = (hh == 0) && (vv == 0);
        p.ls = (hh == 0) && (vv < VA[d]);
        return p;
    endfunction

    function automatic addr_t expect_addr(int d, int hh, int vv);
        addr_t a;
        a = '0;
        if (hh < HA[d] && vv < VA[d]) begin
            a.en = 1'b1;
            a.hc = 7'(hh >> CWL[d]);
            a.ho = 3'(hh & ((1 << CWL[d]) - 1));
            a.vc = 7'(vv >> CHL[d]);
            a.vo = 3'(vv & ((1 << CHL[d]) - 1));
        end
        return a;
    endfunction

    function automatic int at(int q [$], int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    function automatic int count_in(int q [$], int lo, int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One pixel clock: advance the model for the edge just taken, compare, then drive.
    task automatic step(input logic rst_nxt);
        pins_t       e, popped;
        logic [11:0] col;
        @(negedge clk);
        if (!rst) cyc = 0;
        else      cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                h[d] = 0;
                v[d] = 0;
            end else if (h[d] == ht(d) - 1) begin
                h[d] = 0;
                v[d] = (v[d] == vt(d) - 1) ? 0 : v[d] + 1;
            end else begin
                h[d]++;
            end
            check($sformatf("addr%0d", d), 32'(addr_obs[d]), 32'(expect_addr(d, h[d], v[d])));
            col = colour(h[d], v[d]);
            e   = expect_pins(d, h[d], v[d], col);
            if (!rst) begin
                check($sformatf("rst_pins%0d", d), 32'(pins_obs[d]), 32'(idle(d)));
                if (d == 0) begin
                    sb0.delete();
                    repeat (LAT[0]) sb0.push_back(idle(0));
                    sb0.push_back(e);
                end else begin
                    sb1.delete();
                    repeat (LAT[1]) sb1.push_back(idle(1));
                    sb1.push_back(e);
                end
            end else begin
                if (d == 0) begin
                    popped = sb0.pop_front();
                    sb0.push_back(e);
                end else begin
                    popped = sb1.pop_front();
                    sb1.push_back(e);
                end
                check($sformatf("pins%0d", d), 32'(pins_obs[d]), 32'(popped));
            end
            for (int k = 4; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = col;
            px[d] = hist[d][LAT[d]];
        end
        if (prev_hs0 && !d0_hs) hs_fall0.push_back(cyc);
        if (!prev_hs0 && d0_hs) hs_rise0.push_back(cyc);
        if (!prev_vs1 && d1_vs) vs1_rise.push_back(cyc);
        if (prev_vs1 && !d1_vs) vs1_fall.push_back(cyc);
        if (d0_fs) fs0.push_back(cyc);
        if (d0_ls) ls0.push_back(cyc);
        if (d1_fs) fs1.push_back(cyc);
        if (d1_ls) ls1.push_back(cyc);
        prev_hs0 = d0_hs;
        prev_vs1 = d1_vs;
        if (rst && cyc == 639) a639 = addr_obs[0];
        if (rst && cyc == 640) a640 = addr_obs[0];
        if (rst && cyc == 183) b183 = addr_obs[1];
        if (rst && cyc == 184) b184 = addr_obs[1];
        rst = rst_nxt;
    endtask

    task automatic clear_events();
        hs_fall0.delete(); hs_rise0.delete(); fs0.delete(); ls0.delete();
        fs1.delete(); ls1.delete(); vs1_rise.delete(); vs1_fall.delete();
    endtask

    initial begin
        rst      = 1'b0;
        px[0]    = '0;
        px[1]    = '0;
        prev_hs0 = 1'b1;
        prev_vs1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            h[d] = 0;
            v[d] = 0;
            for (int k = 0; k < 5; k++) hist[d][k] = '0;
        end

        // Power-up reset, release so that cycle 0 is the first counted cycle.
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (2500) step(1'b1);

        check("hs0_fall",      32'(at(hs_fall0, 0)), 32'(658));
        check("hs0_rise",      32'(at(hs_rise0, 0)), 32'(754));
        check("hs0_fall2",     32'(at(hs_fall0, 1)), 32'(1458));
        check("fs0_first",     32'(at(fs0, 0)), 32'(2));
        check("fs0_count",     32'(fs0.size()), 32'(1));
        check("ls0_count",     32'(count_in(ls0, 0, 2500)), 32'(4));
        check("fs1_first",     32'(at(fs1, 0)), 32'(4));
        check("fs1_period",    32'(at(fs1, 1) - at(fs1, 0)), 32'(312));
        check("fs1_third",     32'(at(fs1, 2)), 32'(628));
        check("ls1_per_frame", 32'(count_in(ls1, 4, 316)), 32'(8));
        check("vs1_rise",      32'(at(vs1_rise, 0)), 32'(220));
        check("vs1_width",     32'(at(vs1_fall, 0) - at(vs1_rise, 0)), 32'(48));
        check("addr0_639",     32'(a639), 32'(addr_t'{1'b1, 7'd79, 7'd0, 3'd7, 3'd0}));
        check("addr0_640",     32'(a640), 32'(0));
        check("addr1_last",    32'(b183), 32'(addr_t'{1'b1, 7'd3, 7'd1, 3'd3, 3'd3}));
        check("addr1_past",    32'(b184), 32'(0));

        // Mid-frame reset held for five edges, then a fresh frame.
        repeat (150) step(1'b1);
        step(1'b0);
        clear_events();
        repeat (4) step(1'b0);
        step(1'b1);
        repeat (700) step(1'b1);

        check("rst_fs0_first",  32'(at(fs0, 0)), 32'(2));
        check("rst_fs1_first",  32'(at(fs1, 0)), 32'(4));
        check("rst_fs1_second", 32'(at(fs1, 1)), 32'(316));
        check("rst_hs0_fall",   32'(at(hs_fall0, 0)), 32'(658));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
